// File: rtl/signmag_decode_serial.sv
// signmag_decode_serial
//   Converts a two's-complement operand into sign-magnitude form.
//   Non-negative operands pass straight through in one cycle. Negative
//   operands are negated bit-serially, LSB first, using the classic
//   "copy up to and including the first 1, then invert" rule:
//   out bit = in bit XOR seen_one.
//   Latency is 1 cycle for non-negative operands and WIDTH+1 cycles for
//   negative operands.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block can accept an operand (IDLE only)
//   in_data    two's-complement operand, captured on the accept edge
//   out_valid  out_sign/out_mag hold a valid result
//   out_ready  consumer accepts the result
//   out_sign   1 = operand was negative
//   out_mag    unsigned magnitude (-2^(WIDTH-1) maps to 2^(WIDTH-1))
//   busy       high while an operand is in flight (SHIFT or DONE)

module signmag_decode_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             seen_one;
    logic             accept;

    // One step of serial two's-complement negation: bits below and including
    // the first 1 pass unchanged, every later bit is inverted.
    function automatic logic neg_bit(input logic b, input logic seen);
        return b ^ seen;
    endfunction

    assign accept = (state_q == IDLE) && in_valid;

    // ---- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data[WIDTH-1] ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // in_valid is not looked at here, so a handshake edge never
                // doubles as an accept edge.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
        out_valid = (state_q == DONE);
    end

    // ---- operand capture (data only, needs no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= in_data;
        end else if (state_q == SHIFT) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // ---- result and serial-negation control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign <= 1'b0;
            out_mag  <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
        end else if (accept) begin
            out_sign <= in_data[WIDTH-1];
            cnt      <= '0;
            seen_one <= 1'b0;
            if (!in_data[WIDTH-1]) begin
                out_mag <= in_data;
            end
        end else if (state_q == SHIFT) begin
            // Fill from the MSB side so the first (LSB) bit ends at bit 0.
            out_mag  <= {neg_bit(shreg[0], seen_one), out_mag[WIDTH-1:1]};
            seen_one <= seen_one | shreg[0];
            cnt      <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_signmag_decode_serial.sv
module tb_signmag_decode_serial;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [7:0] out_mag;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sign;
        logic [7:0] mag;
        int         lat;
    } exp_t;

    exp_t sb[$];

    signmag_decode_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d);
        exp_t m;
        m.sign = d[7];
        m.mag  = d[7] ? 8'(256 - int'(d)) : d;
        m.lat  = d[7] ? 9 : 1;
        return m;
    endfunction

    // mode 0: plain, 1: stray in_valid (0x11) during SHIFT,
    // 2: in_valid held high on the output handshake edge
    task automatic run_op(input logic [7:0] d, input int stall, input int mode);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(model(d));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("in_ready_shift", in_ready, 0);
            chk("busy_shift", busy, 1);
            if (mode == 1 && lat == 3) begin
                in_valid = 1'b1;
                in_data  = 8'h11;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("sign", out_sign, e.sign);
        chk("mag", out_mag, e.mag);
        out_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_sign", out_sign, e.sign);
            chk("stall_mag", out_mag, e.mag);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_busy", busy, 1);
        end
        out_ready = 1'b1;
        if (mode == 2) begin
            in_valid = 1'b1;
            in_data  = 8'h05;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_mag_hold", out_mag, e.mag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sign", out_sign, 0);
        chk("rst_out_mag", out_mag, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h05, 0, 0);
        run_op(8'hFF, 0, 0);
        run_op(8'h80, 0, 0);
        run_op(8'h00, 0, 0);
        run_op(8'hEC, 5, 0);
        run_op(8'h9C, 0, 1);
        run_op(8'h81, 1, 2);
        run_op(8'h7F, 0, 2);
        run_op(8'h01, 0, 0);

        // reset on the 4th SHIFT cycle of 0xC3
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midshift_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_mag", out_mag, 0);
        chk("midrst_out_sign", out_sign, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(8'h7F, 0, 0);

        for (int k = 0; k < 20; k++) begin
            run_op(8'($urandom), int'($urandom_range(0, 2)), 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
